// File: rtl/cpu_run_ctrl.sv
// Run controller for a CPU core: holds it in reset, runs it against a cycle budget, and
// reports halt/timeout with cycle and retire counts. Define CPU_RUN_CTRL_STEP_EN for single-step.
module cpu_run_ctrl #(
    parameter int RESET_CYCLES = 2,
    parameter int MAX_CYCLES   = 50,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             halt,
    input  logic             retire,
`ifdef CPU_RUN_CTRL_STEP_EN
    input  logic             step_mode,
    input  logic             step_req,
`endif
    output logic             cpu_reset,
    output logic             cpu_en,
    output logic             busy,
    output logic             done,
    output logic             halted,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [1:0] {IDLE, RST, RUN, DONE} state_e;

    localparam logic [7:0]       RST_LOAD   = 8'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(MAX_CYCLES - 1);

    state_e           state_q, state_d;
    logic [7:0]       rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] instr_q, instr_d;
    logic             halted_q, halted_d;
    logic             timeout_q, timeout_d;
    logic             done_q, done_d;
    logic             cpu_reset_q, cpu_reset_d;
    logic             cpu_en_q, cpu_en_d;
    logic             busy_q, busy_d;
    logic             step_ok;

`ifdef CPU_RUN_CTRL_STEP_EN
    logic step_req_q;

    always_ff @(posedge clk) begin
        if (reset) step_req_q <= 1'b0;
        else       step_req_q <= step_req;
    end

    assign step_ok = !step_mode || (step_req && !step_req_q);
`else
    assign step_ok = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        cycle_d   = cycle_q;
        instr_d   = instr_q;
        halted_d  = halted_q;
        timeout_d = timeout_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = RST;
                    rst_cnt_d = RST_LOAD;
                    cycle_d   = '0;
                    instr_d   = '0;
                    halted_d  = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            RST: begin
                if (rst_cnt_q == 8'd0) state_d = RUN;
                else                   rst_cnt_d = rst_cnt_q - 8'd1;
            end
            RUN: begin
                // cpu_en_q marks the cycles the core actually advanced; only those count
                if (cpu_en_q) begin
                    if (cycle_q != '1)           cycle_d = cycle_q + 1'b1;
                    if (retire && instr_q != '1) instr_d = instr_q + 1'b1;
                    if (halt) begin
                        halted_d = 1'b1;
                        done_d   = 1'b1;
                        state_d  = DONE;
                    end else if (cycle_q == LAST_CYCLE) begin
                        timeout_d = 1'b1;
                        done_d    = 1'b1;
                        state_d   = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state and registered alongside it
        cpu_reset_d = (state_d == IDLE) || (state_d == RST);
        busy_d      = (state_d == RST) || (state_d == RUN);
        cpu_en_d    = (state_d == RUN) && step_ok;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rst_cnt_q   <= '0;
            cycle_q     <= '0;
            instr_q     <= '0;
            halted_q    <= 1'b0;
            timeout_q   <= 1'b0;
            done_q      <= 1'b0;
            cpu_reset_q <= 1'b1;
            cpu_en_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            cycle_q     <= cycle_d;
            instr_q     <= instr_d;
            halted_q    <= halted_d;
            timeout_q   <= timeout_d;
            done_q      <= done_d;
            cpu_reset_q <= cpu_reset_d;
            cpu_en_q    <= cpu_en_d;
            busy_q      <= busy_d;
        end
    end

    assign cpu_reset = cpu_reset_q;
    assign cpu_en    = cpu_en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign halted    = halted_q;
    assign timeout   = timeout_q;
    assign cycle_cnt = cycle_q;
    assign instr_cnt = instr_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: stimulus pushes the expected end-of-run result,
// a monitor pops and compares it on every done pulse.
module tb_cpu_run_ctrl;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             halt = 1'b0;
    logic             retire = 1'b0;
`ifdef CPU_RUN_CTRL_STEP_EN
    logic             step_mode = 1'b0;
    logic             step_req = 1'b0;
`endif
    logic             cpu_reset, cpu_en, busy, done, halted, timeout;
    logic [CNT_W-1:0] cycle_cnt, instr_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic h;
        logic t;
        int   c;
        int   i;
    } exp_t;

    exp_t sb[$];

    cpu_run_ctrl #(
        .RESET_CYCLES(2),
        .MAX_CYCLES  (50),
        .CNT_W       (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .halt     (halt),
        .retire   (retire),
`ifdef CPU_RUN_CTRL_STEP_EN
        .step_mode(step_mode),
        .step_req (step_req),
`endif
        .cpu_reset(cpu_reset),
        .cpu_en   (cpu_en),
        .busy     (busy),
        .done     (done),
        .halted   (halted),
        .timeout  (timeout),
        .cycle_cnt(cycle_cnt),
        .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: each done pulse consumes one expected run result
    always @(negedge clk) begin
        if (!reset && done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_halted",  32'(halted),    32'(e.h));
                chk("done_timeout", 32'(timeout),   32'(e.t));
                chk("done_cycles",  32'(cycle_cnt), 32'(e.c));
                chk("done_instrs",  32'(instr_cnt), 32'(e.i));
                chk("done_cpu_en",  32'(cpu_en),    32'd0);
                chk("done_busy",    32'(busy),      32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
        chk({tag, "_cpu_en"},    32'(cpu_en),    32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_done"},      32'(done),      32'd0);
        chk({tag, "_halted"},    32'(halted),    32'd0);
        chk({tag, "_timeout"},   32'(timeout),   32'd0);
        chk({tag, "_cycles"},    32'(cycle_cnt), 32'd0);
        chk({tag, "_instrs"},    32'(instr_cnt), 32'd0);
    endtask

    // Pulse start for one cycle and walk through the two reset cycles into RUN cycle 1
    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rst1_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst1_busy",      32'(busy),      32'd1);
        chk("rst1_cpu_en",    32'(cpu_en),    32'd0);
        chk("rst1_cycles",    32'(cycle_cnt), 32'd0);
        chk("rst1_instrs",    32'(instr_cnt), 32'd0);
        chk("rst1_flags",     32'({halted, timeout}), 32'd0);
        tick();
        chk("rst2_cpu_reset", 32'(cpu_reset), 32'd1);
        tick();
        chk("run1_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("run1_cpu_en",    32'(cpu_en),    32'd1);
    endtask

    task automatic run_cycles(input int n, input bit halt_last, input logic [31:0] retire_mask);
        for (int i = 0; i < n; i++) begin
            retire = retire_mask[i];
            halt   = halt_last && (i == n - 1);
            tick();
        end
        retire = 1'b0;
        halt   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, during and after reset
        #1;
        tick();
        tick();
        chk_idle("in_reset");
        reset = 1'b0;
        tick();
        chk_idle("idle");

        // Halt on the 10th RUN cycle
        sb.push_back('{h: 1'b1, t: 1'b0, c: 10, i: 0});
        start_run();
        run_cycles(10, 1'b1, 32'd0);
        tick();
        chk("halt10_done_once", 32'(done),      32'd0);
        chk("halt10_sticky",    32'(halted),    32'd1);
        chk("halt10_hold_cnt",  32'(cycle_cnt), 32'd10);
        chk("halt10_cpu_reset", 32'(cpu_reset), 32'd0);

        // Budget exhaustion after exactly 50 RUN cycles
        sb.push_back('{h: 1'b0, t: 1'b1, c: 50, i: 0});
        start_run();
        run_cycles(49, 1'b0, 32'd0);
        chk("budget49_busy",    32'(busy),    32'd1);
        chk("budget49_cpu_en",  32'(cpu_en),  32'd1);
        chk("budget49_timeout", 32'(timeout), 32'd0);
        run_cycles(1, 1'b0, 32'd0);
        tick();
        chk("budget_after_cpu_en", 32'(cpu_en), 32'd0);

        // Halt coinciding with the budget: halt wins
        sb.push_back('{h: 1'b1, t: 1'b0, c: 50, i: 0});
        start_run();
        run_cycles(50, 1'b1, 32'd0);
        tick();

        // 7 retires over 20 cycles, the last one on the halt cycle
        sb.push_back('{h: 1'b1, t: 1'b0, c: 20, i: 7});
        start_run();
        run_cycles(20, 1'b1, 32'b1000_0100_1010_0010_0101);
        tick();
        chk("retire_hold_instrs", 32'(instr_cnt), 32'd7);

        // Restart from DONE clears everything, then start is ignored in RUN and reset wins mid-run
        start_run();
        for (int i = 0; i < 24; i++) begin
            start = (i % 5 == 2);
            tick();
        end
        start = 1'b0;
        chk("run25_cycles", 32'(cycle_cnt), 32'd24);
        chk("run25_busy",   32'(busy),      32'd1);
        reset = 1'b1;
        start = 1'b1;
        tick();
        chk_idle("midrun_reset");
        tick();
        chk("reset_over_start_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        start = 1'b0;
        tick();
        chk("post_reset_busy", 32'(busy), 32'd0);

        // Short run with continuous retire
        sb.push_back('{h: 1'b1, t: 1'b0, c: 3, i: 3});
        start_run();
        run_cycles(3, 1'b1, 32'hFFFF_FFFF);
        tick();

`ifdef CPU_RUN_CTRL_STEP_EN
        begin
            int en_seen;
            en_seen = 0;
            step_mode = 1'b1;
            start = 1'b1;
            tick();
            start = 1'b0;
            tick();
            tick();
            for (int p = 0; p < 5; p++) begin
                for (int k = 0; k < 4; k++) begin
                    step_req = (k < 2);
                    tick();
                    if (cpu_en) en_seen++;
                end
            end
            step_req = 1'b0;
            for (int k = 0; k < 3; k++) begin
                tick();
                if (cpu_en) en_seen++;
            end
            chk("step_en_pulses", 32'(en_seen),   32'd5);
            chk("step_cycles",    32'(cycle_cnt), 32'd5);
            step_mode = 1'b0;
            reset = 1'b1;
            tick();
            reset = 1'b0;
            tick();
        end
`endif

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
